// File: rtl/rom_pkg.sv
// Shared definitions for the ROM stream reader: read latency, default widths
// and the sequencer state encoding.
package rom_pkg;

    localparam int ROM_RD_LATENCY = 1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready word stream produced by the ROM stream reader.
interface rom_stream_reader_if
    import rom_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head word. dout is valid while
// empty=0 and stays unchanged until the head is popped.
module sync_fifo
    import rom_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int FIFO_DEPTH = 2,
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic [PTR_W-1:0]      wr_ptr_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  do_push;
    logic                  do_pop;

    // Pointer advance with wrap at FIFO_DEPTH, so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty      = (cnt == '0);
    assign full       = (cnt == CNT_W'(FIFO_DEPTH));
    assign count      = cnt;
    assign do_pop     = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push    = push & (~full | do_pop);
    assign rd_ptr_nxt = ptr_inc(rd_ptr);
    assign wr_ptr_nxt = ptr_inc(wr_ptr);

    // Storage array; holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head register: follows the next stored word on a pop, or takes din when
    // the FIFO is (or is about to become) empty as a word arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (do_pop && (cnt > CNT_W'(1))) begin
            dout <= mem[rd_ptr_nxt];
        end else if (do_push && (empty || (do_pop && (cnt == CNT_W'(1))))) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Sequencer in front of a single-port ROM with a registered q output. On a
// start command it reads `length` consecutive words from `base_addr` and
// streams them out through a small FIFO that absorbs the ROM latency and
// downstream backpressure.
module rom_stream_reader
    import rom_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int FIFO_DEPTH = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    rom_stream_reader_if.master   strm
);

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic                  pending;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  drain_done;
    logic [CNT_W:0]        committed;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    assign pop = ~fifo_empty & strm.out_ready;

    // Words already owed to the FIFO after this edge: stored + arriving - leaving.
    assign committed = {1'b0, fifo_count} + (CNT_W + 1)'(pending) - (CNT_W + 1)'(pop);

    // A read may be issued only if its word is guaranteed a FIFO slot when it
    // arrives one edge later, even if the consumer stalls from now on.
    assign issue = (state == RUN) && (issue_cnt < len_q) &&
                   (committed < (CNT_W + 1)'(FIFO_DEPTH)) && !(fifo_full && !pop);

    assign last_issue = (issue_cnt + (ADDR_WIDTH + 1)'(1)) == len_q;

    // The last word leaves on the cycle it is handshaken with nothing in flight.
    assign drain_done = !pending &&
                        (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Sequencer: command latch, read issue and transfer completion.
    // rom_addr always holds the address the ROM samples at the next edge, so
    // an issue commits that read and moves rom_addr on to the following word
    // (wrapping modulo 2**ADDR_WIDTH). The first address is loaded by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            pending   <= 1'b0;
        end else begin
            pending <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= length;
                        issue_cnt <= '0;
                        if (length != '0) begin
                            rom_addr <= base_addr;
                            state    <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + (ADDR_WIDTH + 1)'(1);
                        if (last_issue) begin
                            state <= DRAIN;
                        end else begin
                            rom_addr <= rom_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pending),
        .din   (rom_q),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign strm.out_data  = fifo_dout;
    assign strm.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader with a registered-output ROM model.
module tb_rom_stream_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;
    logic [7:0] rom_addr;
    logic [7:0] rom_q;
    logic [7:0] rom_mem [256];

    rom_stream_reader_if #(.DATA_WIDTH(8)) sif ();

    rom_stream_reader #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .strm      (sif)
    );

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         first_k;
        int         done_k;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         hs_cnt = 0;
    int         occ_max = 0;
    logic [7:0] exp_q [$];
    logic [7:0] addr_log [8];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
    end

    // ROM model: q is registered, so it shows the word at the previous cycle's address.
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Stream monitor: scoreboard pop on each handshake, hold check during stalls.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(sif.out_valid), 32'd1);
                chk("hold_data", 32'(sif.out_data), 32'(prev_data));
            end
            if (int'(dut.fifo_count) > occ_max) occ_max = int'(dut.fifo_count);
            if (sif.out_valid && sif.out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_extra: got word %0h, required no word", sif.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", 32'(sif.out_data), 32'(e));
                end
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_data  = sif.out_data;
        end
    end

    // Starts a transfer and follows it cycle by cycle; k counts cycles after the start edge.
    task automatic run_transfer(input logic [7:0] b, input logic [8:0] l, input logic [5:0] pat,
                                output int first_k, output int done_k, output int n_done,
                                output int idle_after);
        first_k    = -1;
        done_k     = -1;
        n_done     = 0;
        idle_after = 0;
        for (int i = 0; i < int'(l); i++) exp_q.push_back(8'(b + 8'(i)) ^ 8'hA5);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        @(posedge clk) #1;
        start = 1'b0;
        for (int k = 0; k < 700; k++) begin
            sif.out_ready = pat[k % 6];
            @(negedge clk);
            if (k < 8) addr_log[k] = rom_addr;
            if (sif.out_valid && first_k < 0) first_k = k;
            if (done) begin
                n_done++;
                done_k = k;
            end
            if (done_k >= 0 && k == done_k + 1) begin
                idle_after = busy ? 0 : 1;
                break;
            end
            @(posedge clk) #1;
        end
        @(posedge clk) #1;
    endtask

    initial begin
        vec_t vecs [6];
        int   fk, dk, nd, ia;
        int   guard, nvalid, nbusy, ndone;

        vecs[0] = '{8'h10, 9'd4,   2, 6};
        vecs[1] = '{8'h00, 9'd1,   2, 3};
        vecs[2] = '{8'hF0, 9'd2,   2, 4};
        vecs[3] = '{8'h80, 9'd7,   2, 9};
        vecs[4] = '{8'h33, 9'd0,  -1, 0};
        vecs[5] = '{8'h40, 9'd256, 2, 258};

        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        length        = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_out_data", 32'(sif.out_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk) #1;

        // Table-driven transfers with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            run_transfer(vecs[i].base, vecs[i].len, 6'b111111, fk, dk, nd, ia);
            chk($sformatf("v%0d_first_valid", i), 32'(fk), 32'(vecs[i].first_k));
            chk($sformatf("v%0d_done_cycle", i), 32'(dk), 32'(vecs[i].done_k));
            chk($sformatf("v%0d_done_count", i), 32'(nd), 32'd1);
            chk($sformatf("v%0d_idle_after", i), 32'(ia), 32'd1);
            chk($sformatf("v%0d_sb_empty", i), 32'(exp_q.size()), 32'd0);
        end

        // Wrap-around past the top of the address space.
        run_transfer(8'hFE, 9'd4, 6'b111111, fk, dk, nd, ia);
        chk("wrap_addr0", 32'(addr_log[0]), 32'hFE);
        chk("wrap_addr1", 32'(addr_log[1]), 32'hFF);
        chk("wrap_addr2", 32'(addr_log[2]), 32'h00);
        chk("wrap_addr3", 32'(addr_log[3]), 32'h01);
        chk("wrap_done_count", 32'(nd), 32'd1);
        chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: ready pattern 1,0,0,1,0,1 repeating.
        occ_max = 0;
        run_transfer(8'h00, 9'd6, 6'b101001, fk, dk, nd, ia);
        chk("bp_done_count", 32'(nd), 32'd1);
        chk("bp_idle_after", 32'(ia), 32'd1);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("bp_occ_le_2", 32'(occ_max <= 2), 32'd1);

        // Zero length, with a second start held through the DONE cycle.
        start     = 1'b1;
        base_addr = 8'h33;
        length    = 9'd0;
        @(posedge clk) #1;
        base_addr = 8'h10;
        length    = 9'd3;
        @(negedge clk);
        chk("zl_busy", 32'(busy), 32'd1);
        chk("zl_done", 32'(done), 32'd1);
        chk("zl_valid", 32'(sif.out_valid), 32'd0);
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        chk("zl_busy_after", 32'(busy), 32'd0);
        chk("zl_done_after", 32'(done), 32'd0);
        nvalid = 0;
        nbusy  = 0;
        repeat (4) begin
            @(negedge clk);
            if (sif.out_valid) nvalid++;
            if (busy) nbusy++;
        end
        chk("zl_ignored_valid", 32'(nvalid), 32'd0);
        chk("zl_ignored_busy", 32'(nbusy), 32'd0);
        @(posedge clk) #1;

        // Reset after the third handshake of an 8-word transfer.
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h60 + 8'(i)) ^ 8'hA5);
        start         = 1'b1;
        base_addr     = 8'h60;
        length        = 9'd8;
        sif.out_ready = 1'b1;
        hs_cnt        = 0;
        @(posedge clk) #1;
        start = 1'b0;
        guard = 0;
        while (hs_cnt < 3 && guard < 50) begin
            @(posedge clk) #1;
            guard++;
        end
        chk("mr_reached_3rd", 32'(hs_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_valid", 32'(sif.out_valid), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk) #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || sif.out_valid) ndone++;
        end
        chk("mr_quiet_after", 32'(ndone), 32'd0);
        @(posedge clk) #1;
        run_transfer(8'h20, 9'd2, 6'b111111, fk, dk, nd, ia);
        chk("mr_new_first", 32'(fk), 32'd2);
        chk("mr_new_done", 32'(dk), 32'd4);
        chk("mr_new_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
